echo_counter_mc: RTL and testbench

Multi-channel, parametrised echo-width counter for the ultrasonic parking sensor front end. Each channel is armed per ping and waits a bounded time for the echo rising edge. It then counts echo high-time in clock cycles and reports the width as distance_raw with a one-cycle valid strobe. Timeout and overflow are flagged separately. The block sits between the transducer receive comparators and the distance/zone logic.

---
 rtl/echo_counter_mc.sv | 192 +++++++++++++++++++
 tb/tb_echo_counter_mc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_counter_mc.sv
`default_nettype none
// ============================================================================
//  Module      : echo_counter_mc
//  Description : Multi-channel ultrasonic echo-width counter. Each channel is
//                armed per ping, waits a bounded time for the echo rising edge,
//                then counts the echo high-time and reports it with a strobe.
//                Optional macro ECHO_GLITCH_FILTER_EN adds a FILT_LEN-cycle
//                stability filter behind each synchroniser.
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_counter_mc #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 16,
    parameter int WAIT_W       = 20,
    parameter int WAIT_TIMEOUT = 20000,
    parameter int MAX_PULSE    = 65535,
    parameter int FILT_LEN     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable_count,
    input  logic [NUM_CH-1:0]       arm,
    input  logic [NUM_CH-1:0]       echo_pulse,
    output logic [NUM_CH*CNT_W-1:0] distance_raw,
    output logic [NUM_CH-1:0]       dist_valid,
    output logic [NUM_CH-1:0]       timeout_pulse,
    output logic [NUM_CH-1:0]       ovf_pulse,
    output logic [NUM_CH-1:0]       busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEASURE   = 2'd2,
        ST_HOLDOFF   = 2'd3
    } state_t;

    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(WAIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  c_cnt_last  = CNT_W'(MAX_PULSE - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max   = CNT_W'(MAX_PULSE);

`ifndef ECHO_GLITCH_FILTER_EN
    // The filter length only matters when the glitch filter is built in.
    logic w_filt_len_unused;
    assign w_filt_len_unused = (FILT_LEN > 0);
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic              r_sync1;
        logic              r_sync2;
        logic              r_echo_q;
        logic              w_echo_s;
        logic              w_rise;
        state_t            r_state;
        state_t            w_state_nxt;
        logic [WAIT_W-1:0] r_timer;
        logic [WAIT_W-1:0] w_timer_nxt;
        logic [CNT_W-1:0]  r_cnt;
        logic [CNT_W-1:0]  w_cnt_nxt;
        logic [CNT_W-1:0]  r_dist;
        logic [CNT_W-1:0]  w_dist_nxt;
        logic              r_valid;
        logic              w_valid_nxt;
        logic              r_tmo;
        logic              w_tmo_nxt;
        logic              r_ovf;
        logic              w_ovf_nxt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= echo_pulse[i];
                r_sync2 <= r_sync1;
            end
        end

`ifdef ECHO_GLITCH_FILTER_EN
        localparam int c_fcnt_w = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
        localparam logic [c_fcnt_w-1:0] c_fcnt_last = c_fcnt_w'(FILT_LEN - 1);

        logic                r_filt;
        logic [c_fcnt_w-1:0] r_fcnt;

        // Level follows the synchronised input only after FILT_LEN agreeing samples.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_filt <= 1'b0;
                r_fcnt <= '0;
            end else if (r_sync2 == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == c_fcnt_last) begin
                r_filt <= r_sync2;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end

        assign w_echo_s = r_filt;
`else
        assign w_echo_s = r_sync2;
`endif

        assign w_rise = w_echo_s & ~r_echo_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_echo_q <= 1'b0;
                r_state  <= ST_IDLE;
                r_timer  <= '0;
                r_cnt    <= '0;
                r_dist   <= '0;
                r_valid  <= 1'b0;
                r_tmo    <= 1'b0;
                r_ovf    <= 1'b0;
            end else begin
                r_echo_q <= w_echo_s;
                r_state  <= w_state_nxt;
                r_timer  <= w_timer_nxt;
                r_cnt    <= w_cnt_nxt;
                r_dist   <= w_dist_nxt;
                r_valid  <= w_valid_nxt;
                r_tmo    <= w_tmo_nxt;
                r_ovf    <= w_ovf_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_timer_nxt = r_timer;
            w_cnt_nxt   = r_cnt;
            w_dist_nxt  = r_dist;
            w_valid_nxt = 1'b0;
            w_tmo_nxt   = 1'b0;
            w_ovf_nxt   = 1'b0;
            if (enable_count) begin
                case (r_state)
                    ST_IDLE: begin
                        if (arm[i]) begin
                            w_state_nxt = ST_WAIT_RISE;
                            w_timer_nxt = '0;
                        end
                    end
                    ST_WAIT_RISE: begin
                        // A rising edge on the final wait cycle still starts a measurement.
                        if (w_rise) begin
                            w_state_nxt = ST_MEASURE;
                            w_cnt_nxt   = CNT_W'(1);
                        end else if (r_timer == c_wait_last) begin
                            w_state_nxt = ST_IDLE;
                            w_tmo_nxt   = 1'b1;
                        end else begin
                            w_timer_nxt = r_timer + 1'b1;
                        end
                    end
                    ST_MEASURE: begin
                        if (!w_echo_s) begin
                            w_state_nxt = ST_IDLE;
                            w_dist_nxt  = r_cnt;
                            w_valid_nxt = 1'b1;
                        end else if (r_cnt >= c_cnt_last) begin
                            w_state_nxt = ST_HOLDOFF;
                            w_dist_nxt  = c_cnt_max;
                            w_valid_nxt = 1'b1;
                            w_ovf_nxt   = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (!w_echo_s) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end
        end

        assign distance_raw[i*CNT_W +: CNT_W] = r_dist;
        assign dist_valid[i]    = r_valid;
        assign timeout_pulse[i] = r_tmo;
        assign ovf_pulse[i]     = r_ovf;
        assign busy[i]          = (r_state != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_echo_counter_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_echo_counter_mc
//  Description : Directed and randomised bench for echo_counter_mc with a
//                behavioural width model; second instance covers overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_echo_counter_mc;

    localparam int NUM_CH       = 4;
    localparam int CNT_W        = 16;
    localparam int WAIT_TIMEOUT = 20000;
    localparam int MAX_DEF      = 65535;
    localparam int MAX_SMALL    = 100;
`ifdef ECHO_GLITCH_FILTER_EN
    localparam int LAT = 3 + 4;
`else
    localparam int LAT = 3;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    enable_count;
    logic [NUM_CH-1:0]       arm;
    logic [NUM_CH-1:0]       echo;
    logic [NUM_CH*CNT_W-1:0] distance_raw;
    logic [NUM_CH-1:0]       dist_valid;
    logic [NUM_CH-1:0]       timeout_pulse;
    logic [NUM_CH-1:0]       ovf_pulse;
    logic [NUM_CH-1:0]       busy;

    logic [0:0]       arm_b;
    logic [0:0]       echo_b;
    logic [CNT_W-1:0] dist_b;
    logic [0:0]       valid_b;
    logic [0:0]       tmo_b;
    logic [0:0]       ovf_b;
    logic [0:0]       busy_b;

    int checks = 0;
    int errors = 0;

    echo_counter_mc #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WAIT_W(20),
        .WAIT_TIMEOUT(WAIT_TIMEOUT), .MAX_PULSE(MAX_DEF), .FILT_LEN(4)
    ) dut (
        .clk(clk), .reset(reset), .enable_count(enable_count),
        .arm(arm), .echo_pulse(echo), .distance_raw(distance_raw),
        .dist_valid(dist_valid), .timeout_pulse(timeout_pulse),
        .ovf_pulse(ovf_pulse), .busy(busy)
    );

    echo_counter_mc #(
        .NUM_CH(1), .CNT_W(CNT_W), .WAIT_W(20),
        .WAIT_TIMEOUT(WAIT_TIMEOUT), .MAX_PULSE(MAX_SMALL), .FILT_LEN(4)
    ) dut_ovf (
        .clk(clk), .reset(reset), .enable_count(enable_count),
        .arm(arm_b), .echo_pulse(echo_b), .distance_raw(dist_b),
        .dist_valid(valid_b), .timeout_pulse(tmo_b),
        .ovf_pulse(ovf_b), .busy(busy_b)
    );

    always #25 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] dist_of(input int ch);
        return distance_raw[ch*CNT_W +: CNT_W];
    endfunction

    // Reference: width is the number of enabled high cycles, saturated at the limit.
    function automatic int model_width(input int high_cycles, input int max_pulse);
        return (high_cycles >= max_pulse) ? max_pulse : high_cycles;
    endfunction

    initial begin
        int nval, lat, bz, nov, ovf_at, busy_fall, ntmo;
        logic [CNT_W-1:0] got;
        int w[NUM_CH];
        int s[NUM_CH];
        int nv[NUM_CH];
        logic [CNT_W-1:0] cap[NUM_CH];
        int total;

        reset = 1'b0; enable_count = 1'b1; arm = '0; echo = '0;
        arm_b = '0; echo_b = '0;
        repeat (3) tick();
        check("rst_dist", distance_raw, 0);
        check("rst_valid", dist_valid, 0);
        check("rst_tmo", timeout_pulse, 0);
        check("rst_ovf", ovf_pulse, 0);
        check("rst_busy", busy, 0);
        check("rst_dist_b", dist_b, 0);
        reset = 1'b1;
        repeat (2) tick();

        // ch0: 200-cycle echo
        arm[0] = 1'b1; tick(); arm[0] = 1'b0;
        check("ch0_busy_armed", busy[0], 1);
        echo[0] = 1'b1; nval = 0;
        repeat (200) begin tick(); if (dist_valid[0]) nval++; end
        echo[0] = 1'b0; lat = -1; got = '0; bz = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (dist_valid[0]) begin
                nval++;
                if (lat < 0) begin lat = c; got = dist_of(0); bz = busy[0]; end
            end
        end
        check("ch0_latency", lat, LAT);
        check("ch0_width", got, model_width(200, MAX_DEF));
        check("ch0_valid_count", nval, 1);
        check("ch0_busy_at_valid", bz, 0);

        // ch1: timeout
        arm[1] = 1'b1; tick(); arm[1] = 1'b0;
        lat = 0;
        while (!timeout_pulse[1] && lat < WAIT_TIMEOUT + 10) begin tick(); lat++; end
        check("ch1_timeout_cycles", lat, WAIT_TIMEOUT);
        check("ch1_busy_after_tmo", busy[1], 0);
        check("ch1_dist_unchanged", dist_of(1), 0);
        check("ch1_no_valid_at_tmo", dist_valid[1], 0);
        tick();
        check("ch1_tmo_one_cycle", timeout_pulse[1], 0);

        // overflow instance, limit 100, echo held 150 cycles
        arm_b = 1'b1; tick(); arm_b = 1'b0;
        echo_b = 1'b1; nval = 0; nov = 0; ovf_at = -1; got = '0; bz = -1;
        for (int c = 1; c <= 150; c++) begin
            tick();
            if (valid_b[0]) nval++;
            if (ovf_b[0]) begin
                nov++;
                if (ovf_at < 0) begin ovf_at = c; got = dist_b; bz = {31'd0, valid_b[0] & busy_b[0]}; end
            end
        end
        check("ovf_cycle", ovf_at, MAX_SMALL - 1 + LAT);
        check("ovf_dist", got, model_width(150, MAX_SMALL));
        check("ovf_valid_and_busy", bz, 1);
        echo_b = 1'b0; busy_fall = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (valid_b[0]) nval++;
            if (ovf_b[0]) nov++;
            if (!busy_b[0] && busy_fall < 0) busy_fall = c;
        end
        check("ovf_busy_fall", busy_fall, LAT);
        check("ovf_valid_count", nval, 1);
        check("ovf_pulse_count", nov, 1);

        // all channels together, randomised widths, re-arm while busy
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                w[i] = (r == 0) ? 10 * (i + 1) : int'($urandom_range(10, 120));
                s[i] = (r == 0) ? 0 : int'($urandom_range(0, 3));
                nv[i] = 0; cap[i] = '0;
            end
            ntmo = 0; nov = 0;
            arm = '1; tick(); arm = '0;
            total = 3 + 120 + LAT + 5;
            for (int c = 0; c < total; c++) begin
                for (int i = 0; i < NUM_CH; i++) echo[i] = (c >= s[i]) && (c < s[i] + w[i]);
                arm = (c == 7) ? '1 : '0;
                tick();
                for (int i = 0; i < NUM_CH; i++) begin
                    if (dist_valid[i]) begin nv[i]++; cap[i] = dist_of(i); end
                    if (timeout_pulse[i]) ntmo++;
                    if (ovf_pulse[i]) nov++;
                end
            end
            echo = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                check($sformatf("multi_r%0d_ch%0d_width", r, i), cap[i], model_width(w[i], MAX_DEF));
                check($sformatf("multi_r%0d_ch%0d_vcount", r, i), nv[i], 1);
            end
            check($sformatf("multi_r%0d_no_tmo_ovf", r), ntmo + nov, 0);
            check($sformatf("multi_r%0d_idle", r), busy, 0);
        end

        // ch2: enable dropped 50 cycles inside a 100-cycle echo; arm ch3 while disabled
        arm[2] = 1'b1; tick(); arm[2] = 1'b0;
        nval = 0; got = '0;
        for (int c = 0; c < 100 + LAT + 10; c++) begin
            echo[2] = (c < 100);
            enable_count = !((c >= 30) && (c < 80));
            arm[3] = (c == 40);
            tick();
            if (dist_valid[2]) begin nval++; got = dist_of(2); end
        end
        enable_count = 1'b1; arm = '0; echo = '0;
        check("en_freeze_width", got, model_width(100 - 50, MAX_DEF));
        check("en_freeze_vcount", nval, 1);
        check("arm_while_disabled_ignored", busy[3], 0);

        // reset in the middle of a ch3 measurement
        arm[3] = 1'b1; tick(); arm[3] = 1'b0;
        echo[3] = 1'b1;
        repeat (20) tick();
        check("rst_mid_busy_before", busy[3], 1);
        #5 reset = 1'b0;
        #1;
        echo[3] = 1'b0;
        check("rst_mid_dist", distance_raw, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_strobes", {dist_valid, timeout_pulse, ovf_pulse}, 0);
        check("rst_mid_dist_b", dist_b, 0);
        tick(); reset = 1'b1;
        nval = 0;
        repeat (10) begin tick(); if (dist_valid != '0 || ovf_pulse != '0) nval++; end
        check("rst_mid_no_strobe", nval, 0);

`ifdef ECHO_GLITCH_FILTER_EN
        // 2-cycle glitch then a 60-cycle echo
        arm[0] = 1'b1; tick(); arm[0] = 1'b0;
        echo[0] = 1'b1; repeat (2) tick();
        echo[0] = 1'b0; repeat (10) tick();
        echo[0] = 1'b1; nval = 0; got = '0;
        repeat (60) begin tick(); if (dist_valid[0]) nval++; end
        echo[0] = 1'b0;
        repeat (LAT + 5) begin tick(); if (dist_valid[0]) begin nval++; got = dist_of(0); end end
        check("filt_width", got, 60);
        check("filt_vcount", nval, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
